// File: rtl/fpu_dispatch.sv
// Request FIFO and single-issue sequencer in front of the double-precision fpu core.
// Results come back in request order, with a timeout guard against a hung core.
module fpu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [1:0]                 req_rmode,
  input  logic [63:0]                req_a,
  input  logic [63:0]                req_b,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       fpu_enable,
  output logic [2:0]                 fpu_operation,
  output logic [1:0]                 fpu_rounding,
  output logic [63:0]                fpu_operand_a,
  output logic [63:0]                fpu_operand_b,
  input  logic [63:0]                fpu_out,
  input  logic                       fpu_ready,
  input  logic                       fpu_underflow,
  input  logic                       fpu_overflow,
  input  logic                       fpu_inexact,
  input  logic                       fpu_exception,
  input  logic                       fpu_invalid,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [63:0]                res_data,
  output logic [4:0]                 res_flags,
  output logic                       res_timeout,
  output logic [TAG_W-1:0]           res_tag,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       rmode;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  state_t           state, state_nxt;
  logic [15:0]      wait_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic             push, issue, slot_free, got_ready, timed_out;

  assign req_ready  = (count != CW'(DEPTH));
  assign fifo_count = count;
  assign push       = req_valid && req_ready;
  assign slot_free  = !res_valid || res_ready;
  assign issue      = (state == IDLE) && (count != '0) && slot_free;
  assign head       = mem[rd_ptr];
  // The first BUSY cycle (wait_cnt==0) ignores a ready left over from the previous op.
  assign got_ready  = (state == BUSY) && (wait_cnt != '0) && fpu_ready;
  assign timed_out  = (state == BUSY) && !got_ready && (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, rmode: req_rmode, a: req_a, b: req_b, tag: req_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (got_ready || timed_out) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fpu_enable = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_operation <= '0;
      fpu_rounding  <= '0;
      fpu_operand_a <= '0;
      fpu_operand_b <= '0;
      cur_tag       <= '0;
      wait_cnt      <= '0;
    end else if (issue) begin
      fpu_operation <= head.op;
      fpu_rounding  <= head.rmode;
      fpu_operand_a <= head.a;
      fpu_operand_b <= head.b;
      cur_tag       <= head.tag;
      wait_cnt      <= '0;
    end else if (state == BUSY) begin
      wait_cnt      <= wait_cnt + 1'b1;
    end
  end

  // Issue only happens with the slot free, so a capture never overwrites a pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_flags   <= '0;
      res_timeout <= 1'b0;
      res_tag     <= '0;
    end else if (got_ready) begin
      res_valid   <= 1'b1;
      res_data    <= fpu_out;
      res_flags   <= {fpu_invalid, fpu_exception, fpu_inexact, fpu_overflow, fpu_underflow};
      res_timeout <= 1'b0;
      res_tag     <= cur_tag;
    end else if (timed_out) begin
      res_valid   <= 1'b1;
      res_data    <= '0;
      res_flags   <= 5'b01000;
      res_timeout <= 1'b1;
      res_tag     <= cur_tag;
    end else if (res_valid && res_ready) begin
      res_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a behavioural fpu model and a result scoreboard.
module tb_fpu_dispatch;
  localparam int DEPTH = 4, TAG_W = 4, TO = 16;

  logic clk = 1'b0, rst;
  logic req_valid, req_ready, res_valid, res_ready, res_timeout;
  logic [2:0] req_op, fpu_operation;
  logic [1:0] req_rmode, fpu_rounding;
  logic [63:0] req_a, req_b, fpu_operand_a, fpu_operand_b, fpu_out, res_data;
  logic [TAG_W-1:0] req_tag, res_tag;
  logic fpu_enable, fpu_ready, fpu_underflow, fpu_overflow, fpu_inexact, fpu_exception, fpu_invalid;
  logic [4:0] res_flags;
  logic [$clog2(DEPTH):0] fifo_count;

  fpu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rmode(req_rmode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_enable(fpu_enable), .fpu_operation(fpu_operation), .fpu_rounding(fpu_rounding),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b), .fpu_out(fpu_out),
    .fpu_ready(fpu_ready), .fpu_underflow(fpu_underflow), .fpu_overflow(fpu_overflow),
    .fpu_inexact(fpu_inexact), .fpu_exception(fpu_exception), .fpu_invalid(fpu_invalid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .res_timeout(res_timeout), .res_tag(res_tag), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      data;
    logic [4:0]       flags;
    logic             to;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] calc(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (op)
      3'd0:    return $realtobits(ra + rb);
      3'd1:    return $realtobits(ra - rb);
      3'd2:    return $realtobits(ra * rb);
      default: return $realtobits(ra / rb);
    endcase
  endfunction

  // fpu model: ready after lat cycles of enable; 'stale' adds a bogus ready in the first cycle.
  int lat = 10, lat_cnt = 0;
  bit hang = 1'b0, stale = 1'b0;
  always @(posedge clk) lat_cnt <= fpu_enable ? lat_cnt + 1 : 0;
  assign fpu_ready = fpu_enable && !hang && (lat_cnt >= lat || (stale && lat_cnt == 0));
  assign {fpu_invalid, fpu_exception, fpu_inexact, fpu_overflow, fpu_underflow} =
         fpu_operand_a[4:0] ^ fpu_operand_b[4:0];
  always_comb begin
    fpu_out = 64'hDEAD_BEEF_0BAD_F00D;
    if (lat_cnt >= lat) fpu_out = calc(fpu_operation, fpu_operand_a, fpu_operand_b);
  end

  res_t got;
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", {res_tag, res_data}, 128'h0);
      else begin
        got = sb.pop_front();
        chk("result", {res_data, res_flags, res_timeout, res_tag}, got);
      end
    end
  end

  // Enable must stay low at least two sampled cycles (DRAIN + IDLE) between ops.
  logic prev_en = 1'b0;
  int low_run = 100;
  always @(negedge clk) begin
    if (fpu_enable && !prev_en) chk("issue_gap", 128'(low_run >= 2), 128'h1);
    low_run <= fpu_enable ? 0 : low_run + 1;
    prev_en <= fpu_enable;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAG_W-1:0] tag, input bit exp_to);
    int w = 0;
    req_valid = 1'b1; req_op = op; req_rmode = 2'(tag); req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && w < 200) begin tick; w++; end
    if (w >= 200) chk("push_accept_bound", 128'(req_ready), 128'h1);
    tick;
    req_valid = 1'b0;
    if (exp_to) sb.push_back('{data: 64'h0, flags: 5'b01000, to: 1'b1, tag: tag});
    else        sb.push_back('{data: calc(op, a, b), flags: a[4:0] ^ b[4:0], to: 1'b0, tag: tag});
  endtask

  task automatic wait_empty(input string name);
    int w = 0;
    while ((sb.size() != 0 || res_valid || fpu_enable || fifo_count != 0) && w < 2000) begin tick; w++; end
    if (w >= 2000) chk(name, 128'(sb.size()), 128'h0);
  endtask

  logic [63:0] av [5] = '{64'h3FF8000000000000, 64'h4024000000000000, 64'h4008000000000000,
                          64'h401C000000000000, 64'hC000000000000005};
  logic [63:0] bv [5] = '{64'h4000000000000001, 64'h3FF0000000000003, 64'h4010000000000010,
                          64'h4000000000000007, 64'h4014000000000000};

  initial begin
    int w;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = '0; req_a = '0; req_b = '0;
    req_tag = '0; res_ready = 1'b1;
    tick; tick;
    chk("rst_ctrl", {req_ready, fifo_count, fpu_enable, res_valid, res_timeout, res_flags, res_tag},
        {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
    chk("rst_res_data", res_data, 0);
    chk("rst_operands", {fpu_operand_a, fpu_operand_b}, 0);
    chk("rst_op_rnd", {fpu_operation, fpu_rounding}, 0);
    rst = 1'b0;
    tick;

    // Single add, result held to inspect it directly.
    res_ready = 1'b0; lat = 10;
    push(3'd0, 64'h3FF0000000000000, 64'h4000000000000000, 4'd5, 1'b0);
    chk("add_en_accept_edge", fpu_enable, 0);
    tick;
    chk("add_en_issue", fpu_enable, 1);
    chk("add_operands", {fpu_operand_a, fpu_operand_b}, {64'h3FF0000000000000, 64'h4000000000000000});
    chk("add_op_rnd", {fpu_operation, fpu_rounding}, {3'd0, 2'd1});
    w = 0;
    while (!res_valid && w < 100) begin tick; w++; end
    chk("add_latency", w, 11);
    chk("add_data", res_data, 64'h4008000000000000);
    chk("add_meta", {res_flags, res_timeout, res_tag}, {5'd0, 1'b0, 4'd5});
    chk("add_en_drop", fpu_enable, 0);

    // Fill the FIFO behind the held result; no issue while the slot is full.
    for (int i = 0; i < 4; i++) push(3'(i), av[i], bv[i], 4'(i), 1'b0);
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", req_ready, 0);
    tick; tick; tick;
    chk("bp_no_issue", fpu_enable, 0);
    chk("bp_hold", {res_valid, res_data, res_tag}, {1'b1, 64'h4008000000000000, 4'd5});
    res_ready = 1'b1;
    tick;
    chk("bp_release_issue", {fpu_enable, fpu_operation, fpu_operand_a}, {1'b1, 3'd0, av[0]});
    chk("bp_release_count", {fifo_count, req_ready}, {3'd3, 1'b1});
    push(3'd3, av[4], bv[4], 4'd4, 1'b0);
    wait_empty("fill_drain_bound");

    // Hung fpu: first op times out, second completes normally.
    hang = 1'b1;
    push(3'd0, av[2], bv[2], 4'd9, 1'b1);
    push(3'd1, av[3], bv[1], 4'd10, 1'b0);
    w = 0;
    while (fpu_enable && w < 100) begin tick; w++; end
    chk("to_busy_cycles", w, TO);
    chk("to_result", {res_valid, res_data, res_flags, res_timeout, res_tag},
        {1'b1, 64'h0, 5'b01000, 1'b1, 4'd9});
    hang = 1'b0;
    wait_empty("to_drain_bound");

    // Ready held high in the first BUSY cycle must not be captured.
    stale = 1'b1; lat = 5;
    push(3'd2, av[1], bv[3], 4'd3, 1'b0);
    wait_empty("stale_drain_bound");
    stale = 1'b0;

    // Reset mid-operation discards everything.
    lat = 12;
    for (int i = 1; i < 5; i++) push(3'd0, av[i], bv[i], 4'(i), 1'b0);
    chk("midop_state", {fifo_count, fpu_enable}, {3'd3, 1'b1});
    rst = 1'b1;
    tick;
    sb.delete();
    chk("midop_reset", {fpu_enable, fifo_count, res_valid, req_ready}, {1'b0, 3'd0, 1'b0, 1'b1});
    rst = 1'b0;
    repeat (30) tick;
    chk("midop_no_result", {res_valid, fpu_enable}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Request buffer and sequencer that sits directly upstream of the double-precision `fpu` core. It accepts FP operation requests over a valid/ready stream and queues them in a small FIFO. It issues them one at a time on the fpu's `enable`/`ready` protocol and returns each result with its five exception flags and a tag on a valid/ready result stream. A timeout guard keeps a hung fpu from locking the pipeline.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the pass-through request tag.
- TIMEOUT, 255: max BUSY cycles waiting for `fpu_ready`; 8..65535.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full (registered, no same-cycle bypass).
- req_op  in  3  fpu operation code (000 add, 001 sub, 010 mul, 011 div).
- req_rmode  in  2  rounding mode, passed to fpu unchanged.
- req_a, req_b  in  64  IEEE-754 double operands.
- req_tag  in  TAG_W  caller tag, returned with result.
- fpu_enable  out  1  fpu `enable`.
- fpu_operation  out  3, fpu_rounding  out  2, fpu_operand_a/b  out  64  registered, stable while fpu_enable=1.
- fpu_out  in  64, fpu_ready  in  1, fpu_underflow/overflow/inexact/exception/invalid  in  1 each.
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accepts.
- res_data  out  64, res_flags  out  5 {invalid,exception,inexact,overflow,underflow}, res_timeout  out  1, res_tag  out  TAG_W.
- fifo_count  out  $clog2(DEPTH)+1  entries currently queued.

## Operation
- FIFO: push on req_valid&&req_ready; pop when FSM leaves IDLE. Simultaneous push and pop leave count unchanged. Pointers wrap mod DEPTH. req_ready = (count != DEPTH), from registered count. A pop in the same cycle does not raise req_ready.
- FSM states: IDLE, BUSY, DRAIN.
  - IDLE → BUSY when count≠0 and the result slot is free (res_valid==0, or res_valid&&res_ready this cycle). On that edge: pop the head, load the fpu_* operand registers, set fpu_enable=1, clear the wait counter.
  - BUSY: hold fpu_enable=1 and operands constant. Increment the wait counter each cycle.
    - fpu_ready is sampled only when counter ≥1; the first BUSY cycle ignores stale ready.
    - On a sampled fpu_ready=1: capture fpu_out, the flags and the tag into the result register; res_timeout=0; go to DRAIN.
    - If the counter reaches TIMEOUT without ready: capture res_data=0, res_flags=5'b01000 (exception), res_timeout=1; go to DRAIN.
  - DRAIN: fpu_enable=0 for exactly one cycle, then go to IDLE unconditionally. This guarantees a low-enable gap between ops.
- Result register: res_valid set on capture and cleared on res_valid&&res_ready. The issue gating guarantees it is never overwritten while full.
- Ordering: results leave in request order; one op in flight maximum.

## Timing
- Reset values: req_ready=1, fifo_count=0, fpu_enable=0, all fpu_* operand outputs 0, res_valid=0, res_data=0, res_flags=0, res_timeout=0, res_tag=0, FSM=IDLE.
- Reset mid-operation: the in-flight op and all queued entries are discarded. fpu_enable drops on the reset edge.
- Request accepted at edge N into an empty FIFO, FSM in IDLE, slot free: fpu_enable=1 after edge N+1.
- fpu_ready sampled high at edge M: res_valid=1 after edge M. fpu_enable=0 after edge M. The next fpu_enable is high no earlier than after edge M+2.
- Minimum issue-to-issue spacing: fpu latency + 3 cycles.
- Result held while res_valid&&!res_ready. A full result slot stalls issue; the FIFO keeps accepting until full.

## Test plan
- Single add: req_a=0x3FF0000000000000, req_b=0x4000000000000000, op=000, tag=5, fpu model latency 10 → fpu_enable high 1 cycle after accept, res_data=0x4008000000000000, res_flags=0, res_tag=5, res_timeout=0.
- Back-to-back fill: push 5 requests with DEPTH=4 and the fpu stalled → req_ready=0 after the 4th accept, fifo_count=4. Results return in tag order 0..4 with one DRAIN cycle of fpu_enable=0 between ops.
- Backpressure: hold res_ready=0 after the first result → no second fpu_enable while res_valid=1. The first result is stable. Releasing res_ready issues the next op the following cycle.
- Timeout: fpu model never asserts ready, TIMEOUT=8 → res_valid after 8 BUSY cycles with res_data=0, res_flags=01000, res_timeout=1. The next queued op then issues normally.
- Stale ready: fpu model holds ready=1 through the first BUSY cycle → not captured. Capture occurs only on a ready seen at counter ≥1.
- Reset mid-op: assert rst during BUSY with 3 entries queued → next cycle fpu_enable=0, fifo_count=0, res_valid=0, req_ready=1. No result is ever emitted for the discarded ops.
